// File: rtl/axis_tx_pkt_buffer.sv
// ---------------------------------------------------------------------------
// axis_tx_pkt_buffer
//
// Store-and-forward AXI-Stream transmit packet buffer placed in front of a
// MAC. A packet is released on the master side only after its tlast beat has
// been accepted and committed. Packets that are flagged bad on their tlast
// beat (s_axis_tuser=1, DROP_ON_ERR=1) are discarded by rewinding the write
// pointer. Packets larger than the whole buffer are discarded as well.
//
// Ports
//   user_clk            sole clock
//   reset               synchronous, active-high
//   s_axis_t*           slave stream input (tuser = error flag on tlast beat)
//   m_axis_t*           master stream output towards the MAC (tuser always 0)
//   pkt_count           committed packets not yet fully sent
//   data_count          words held (wr_ptr - rd_ptr), includes uncommitted
//   drop_count          wrapping count of discarded packets
// ---------------------------------------------------------------------------
module axis_tx_pkt_buffer #(
    parameter int DATA_WIDTH  = 64,
    parameter int DEPTH_LOG2  = 9,
    parameter int MAX_PKTS    = 16,
    parameter int DROP_ON_ERR = 1,
    localparam int KEEP_WIDTH = DATA_WIDTH / 8,
    localparam int CNT_W      = $clog2(MAX_PKTS + 32'd1)
) (
    input  logic                  user_clk,
    input  logic                  reset,

    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tuser,
    output logic                  s_axis_tready,

    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    input  logic                  m_axis_tready,

    output logic [CNT_W-1:0]      pkt_count,
    output logic [DEPTH_LOG2:0]   data_count,
    output logic [31:0]           drop_count
);

    localparam int PW    = DEPTH_LOG2 + 1;
    localparam int DEPTH = 32'd1 << DEPTH_LOG2;
    localparam int WW    = DATA_WIDTH + KEEP_WIDTH + 1;

    localparam logic [PW-1:0]    PTR_ZERO = PW'(0);
    localparam logic [PW-1:0]    PTR_ONE  = PW'(1);
    localparam logic [PW-1:0]    PTR_FULL = PW'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_PKTS);

    typedef enum logic [1:0] {
        WR_IDLE = 2'd0,
        WR_LOAD = 2'd1,
        WR_DROP = 2'd2
    } wr_state_e;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_SEND = 1'b1
    } rd_state_e;

    // Storage word layout: {tlast, tkeep, tdata}
    logic [WW-1:0]         mem_q [DEPTH];

    wr_state_e             wr_state_q;
    rd_state_e             rd_state_q;
    logic [PW-1:0]         wr_ptr_q;
    logic [PW-1:0]         commit_ptr_q;
    logic [PW-1:0]         rd_ptr_q;
    logic [CNT_W-1:0]      pkt_count_q;
    logic [CNT_W-1:0]      pkt_count_d;
    logic [31:0]           drop_count_q;

    logic [DATA_WIDTH-1:0] m_tdata_q;
    logic [KEEP_WIDTH-1:0] m_tkeep_q;
    logic                  m_tlast_q;
    logic                  m_tvalid_q;

    logic                  full_s;
    logic                  s_ready_s;
    logic                  s_accept_s;
    logic                  pkt_err_s;
    logic                  commit_s;
    logic                  send_done_s;
    logic                  fetch_s;
    logic [WW-1:0]         rd_word_s;

    // Input-side handshake and event decode
    always_comb begin
        full_s    = ((wr_ptr_q - rd_ptr_q) == PTR_FULL);
        s_ready_s = 1'b0;
        if (reset) begin
            s_ready_s = 1'b0;
        end else begin
            case (wr_state_q)
                WR_IDLE, WR_LOAD: s_ready_s = !full_s && (pkt_count_q < CNT_MAX);
                WR_DROP:          s_ready_s = 1'b1;
                default:          s_ready_s = 1'b0;
            endcase
        end
        s_accept_s = s_axis_tvalid && s_ready_s;
        pkt_err_s  = (DROP_ON_ERR != 32'sd0) && s_axis_tuser;
        commit_s   = s_accept_s && s_axis_tlast && !pkt_err_s && (wr_state_q != WR_DROP);
    end

    // Output-side event decode; the output register refills whenever it is
    // empty or being drained, so a packet streams without bubbles and the
    // first beat of an already-committed next packet follows tlast directly
    always_comb begin
        rd_word_s   = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
        send_done_s = m_tvalid_q && m_axis_tready && m_tlast_q;
        fetch_s     = (rd_state_q == RD_SEND) && (rd_ptr_q != commit_ptr_q)
                      && (!m_tvalid_q || m_axis_tready);
    end

    // Committed packet count; a commit and a send-complete in the same cycle cancel
    always_comb begin
        pkt_count_d = pkt_count_q;
        if (commit_s && !send_done_s) begin
            pkt_count_d = pkt_count_q + CNT_ONE;
        end else if (send_done_s && !commit_s) begin
            pkt_count_d = pkt_count_q - CNT_ONE;
        end else begin
            pkt_count_d = pkt_count_q;
        end
    end

    // Packet storage write port (contents need no reset, pointers guard them)
    always_ff @(posedge user_clk) begin
        if (s_accept_s && (wr_state_q != WR_DROP)) begin
            mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
        end
    end

    // Write FSM: load, commit or rewind packets, and drop oversize packets
    always_ff @(posedge user_clk) begin
        if (reset) begin
            wr_state_q   <= WR_IDLE;
            wr_ptr_q     <= PTR_ZERO;
            commit_ptr_q <= PTR_ZERO;
            drop_count_q <= 32'd0;
        end else begin
            case (wr_state_q)
                WR_IDLE, WR_LOAD: begin
                    if (s_accept_s) begin
                        if (s_axis_tlast) begin
                            if (pkt_err_s) begin
                                wr_ptr_q     <= commit_ptr_q;
                                drop_count_q <= drop_count_q + 32'd1;
                            end else begin
                                wr_ptr_q     <= wr_ptr_q + PTR_ONE;
                                commit_ptr_q <= wr_ptr_q + PTR_ONE;
                            end
                            wr_state_q <= WR_IDLE;
                        end else begin
                            wr_ptr_q   <= wr_ptr_q + PTR_ONE;
                            wr_state_q <= WR_LOAD;
                        end
                    end else if ((wr_state_q == WR_LOAD) && full_s && (pkt_count_q == CNT_ZERO)) begin
                        // Buffer filled by one packet alone: it can never be
                        // committed, so free the space and swallow the rest
                        wr_ptr_q   <= commit_ptr_q;
                        wr_state_q <= WR_DROP;
                    end else begin
                        wr_state_q <= wr_state_q;
                    end
                end
                WR_DROP: begin
                    if (s_accept_s && s_axis_tlast) begin
                        drop_count_q <= drop_count_q + 32'd1;
                        wr_state_q   <= WR_IDLE;
                    end else begin
                        wr_state_q <= WR_DROP;
                    end
                end
                default: begin
                    wr_state_q <= WR_IDLE;
                end
            endcase
        end
    end

    // Read FSM, output register and committed packet counter
    always_ff @(posedge user_clk) begin
        if (reset) begin
            rd_state_q  <= RD_IDLE;
            rd_ptr_q    <= PTR_ZERO;
            pkt_count_q <= CNT_ZERO;
            m_tvalid_q  <= 1'b0;
            m_tlast_q   <= 1'b0;
            m_tkeep_q   <= {KEEP_WIDTH{1'b0}};
            m_tdata_q   <= {DATA_WIDTH{1'b0}};
        end else begin
            pkt_count_q <= pkt_count_d;

            if (fetch_s) begin
                rd_ptr_q                            <= rd_ptr_q + PTR_ONE;
                {m_tlast_q, m_tkeep_q, m_tdata_q}   <= rd_word_s;
                m_tvalid_q                          <= 1'b1;
            end else if (m_axis_tready) begin
                m_tvalid_q <= 1'b0;
            end else begin
                m_tvalid_q <= m_tvalid_q;
            end

            case (rd_state_q)
                RD_IDLE: begin
                    if (pkt_count_q != CNT_ZERO) begin
                        rd_state_q <= RD_SEND;
                    end else begin
                        rd_state_q <= RD_IDLE;
                    end
                end
                RD_SEND: begin
                    // Stay in SEND only if the next packet's first beat was
                    // loaded in the same cycle the current tlast left
                    if (send_done_s && !fetch_s) begin
                        rd_state_q <= RD_IDLE;
                    end else begin
                        rd_state_q <= RD_SEND;
                    end
                end
                default: begin
                    rd_state_q <= RD_IDLE;
                end
            endcase
        end
    end

    assign s_axis_tready = s_ready_s;
    assign m_axis_tdata  = m_tdata_q;
    assign m_axis_tkeep  = m_tkeep_q;
    assign m_axis_tlast  = m_tlast_q;
    assign m_axis_tvalid = m_tvalid_q;
    assign m_axis_tuser  = 1'b0;
    assign pkt_count     = pkt_count_q;
    assign data_count    = wr_ptr_q - rd_ptr_q;
    assign drop_count    = drop_count_q;

endmodule

// File: tb/tb_axis_tx_pkt_buffer.sv
// ---------------------------------------------------------------------------
// tb_axis_tx_pkt_buffer
//
// Directed and randomized bench for axis_tx_pkt_buffer (16-word buffer,
// two-packet limit, 32-bit data). A packet-level reference model keeps the
// list of beats that must leave the buffer, the committed-packet count and
// the drop count; every master beat is compared against it.
// ---------------------------------------------------------------------------
module tb_axis_tx_pkt_buffer;

    localparam int DW    = 32;
    localparam int KW    = 4;
    localparam int DL2   = 4;
    localparam int MAXP  = 2;
    localparam int DEPTH = 16;
    localparam int CW    = 2;
    localparam int BW    = DW + KW + 1;

    logic          user_clk = 1'b0;
    logic          reset;
    logic [DW-1:0] s_tdata;
    logic [KW-1:0] s_tkeep;
    logic          s_tvalid;
    logic          s_tlast;
    logic          s_tuser;
    logic          s_tready;
    logic [DW-1:0] m_tdata;
    logic [KW-1:0] m_tkeep;
    logic          m_tvalid;
    logic          m_tlast;
    logic          m_tuser;
    logic          m_ready;
    logic [CW-1:0] pkt_count;
    logic [DL2:0]  data_count;
    logic [31:0]   drop_count;

    always #5 user_clk = ~user_clk;

    axis_tx_pkt_buffer #(
        .DATA_WIDTH (DW),
        .DEPTH_LOG2 (DL2),
        .MAX_PKTS   (MAXP),
        .DROP_ON_ERR(1)
    ) dut (
        .user_clk     (user_clk),
        .reset        (reset),
        .s_axis_tdata (s_tdata),
        .s_axis_tkeep (s_tkeep),
        .s_axis_tvalid(s_tvalid),
        .s_axis_tlast (s_tlast),
        .s_axis_tuser (s_tuser),
        .s_axis_tready(s_tready),
        .m_axis_tdata (m_tdata),
        .m_axis_tkeep (m_tkeep),
        .m_axis_tvalid(m_tvalid),
        .m_axis_tlast (m_tlast),
        .m_axis_tuser (m_tuser),
        .m_axis_tready(m_ready),
        .pkt_count    (pkt_count),
        .data_count   (data_count),
        .drop_count   (drop_count)
    );

    // Reference model state
    logic [BW-1:0] exp_q[$];     // beats that must still appear, in order
    logic [BW-1:0] cur_pkt[$];   // beats of the packet being received
    bit            overflow_m;   // current packet exceeded the buffer
    int            cnt_m;        // committed packets not fully sent
    int            drop_m;       // discarded packets

    int            n_checks = 0;
    int            n_fail   = 0;
    bit            rand_ready;
    bit            last_in_acc;
    bit            prev_stall;
    logic [BW-1:0] prev_beat;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        cur_pkt.delete();
        overflow_m = 1'b0;
        cnt_m      = 0;
        drop_m     = 0;
    endtask

    task automatic model_in(input logic [BW-1:0] beat, input logic user);
        if (overflow_m) begin
            if (beat[BW-1]) begin
                drop_m++;
                overflow_m = 1'b0;
            end
        end else begin
            cur_pkt.push_back(beat);
            if (beat[BW-1]) begin
                if (user) begin
                    drop_m++;
                end else begin
                    foreach (cur_pkt[i]) exp_q.push_back(cur_pkt[i]);
                    cnt_m++;
                end
                cur_pkt.delete();
            end
        end
    endtask

    // One clock: score what transfers at the coming edge, then update model
    task automatic cycle();
        bit            in_acc;
        bit            out_acc;
        bit            rst_edge;
        logic [BW-1:0] obeat;
        logic [BW-1:0] ibeat;
        logic          iuser;
        if (rand_ready) m_ready = ($urandom_range(0, 3) != 0);
        obeat = {m_tlast, m_tkeep, m_tdata};
        ibeat = {s_tlast, s_tkeep, s_tdata};
        iuser = s_tuser;
        if (prev_stall) begin
            check("stall_valid", m_tvalid, 1);
            check("stall_beat", obeat, prev_beat);
        end
        rst_edge = reset;
        in_acc   = s_tvalid && s_tready;
        out_acc  = m_tvalid && m_ready && !reset;
        if (out_acc) begin
            check("beat_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) check("out_beat", obeat, exp_q.pop_front());
            check("m_tuser", m_tuser, 0);
        end
        prev_stall = m_tvalid && !m_ready && !reset;
        prev_beat  = obeat;
        @(posedge user_clk);
        #1;
        last_in_acc = in_acc;
        if (rst_edge) begin
            model_clear();
            prev_stall = 1'b0;
        end else begin
            if (in_acc) model_in(ibeat, iuser);
            if (out_acc && obeat[BW-1]) cnt_m--;
            if (!overflow_m && cur_pkt.size() == DEPTH && cnt_m == 0) begin
                overflow_m = 1'b1;
                cur_pkt.delete();
            end
            check("pkt_count", pkt_count, cnt_m);
            check("pkt_le_max", pkt_count <= MAXP, 1);
            check("drop_count", drop_count, drop_m);
        end
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k,
                             input logic l, input logic u);
        int guard;
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tkeep  = k;
        s_tlast  = l;
        s_tuser  = u;
        guard    = 0;
        do begin
            cycle();
            guard++;
        end while (!last_in_acc && guard < 2000);
        check("send_timeout", last_in_acc, 1);
        s_tvalid = 1'b0;
    endtask

    task automatic send_pkt(input int len, input bit err, input bit gaps);
        for (int i = 0; i < len; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) cycle();
            if (i == len - 1) send_beat($urandom(), 4'($urandom_range(1, 15)), 1'b1, err);
            else              send_beat($urandom(), 4'hF, 1'b0, 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic drain(input int budget);
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || cnt_m != 0) && guard < budget) begin
            cycle();
            guard++;
        end
        check("drain_left", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DW-1:0] hold_d;
        logic [KW-1:0] hold_k;
        reset      = 1'b1;
        s_tvalid   = 1'b0;
        s_tdata    = 32'd0;
        s_tkeep    = 4'd0;
        s_tlast    = 1'b0;
        s_tuser    = 1'b0;
        m_ready    = 1'b0;
        rand_ready = 1'b0;
        prev_stall = 1'b0;
        model_clear();

        // Reset state
        #2;
        check("tready_in_reset", s_tready, 0);
        cycle();
        cycle();
        check("rst_valid", m_tvalid, 0);
        check("rst_pkt", pkt_count, 0);
        check("rst_data", data_count, 0);
        check("rst_drop", drop_count, 0);
        reset = 1'b0;
        #1;
        check("tready_after_reset", s_tready, 1);

        // 8-beat good packet: latency, contiguity, counters
        m_ready = 1'b1;
        send_pkt(8, 1'b0, 1'b0);
        check("lat_e0_valid", m_tvalid, 0);
        check("lat_e0_data", data_count, 8);
        cycle();
        check("lat_e1_valid", m_tvalid, 0);
        cycle();
        check("lat_e2_valid", m_tvalid, 1);
        for (int i = 0; i < 8; i++) begin
            check("contig_valid", m_tvalid, 1);
            cycle();
        end
        check("p8_done_valid", m_tvalid, 0);
        check("p8_done_pkt", pkt_count, 0);
        check("p8_done_data", data_count, 0);

        // Errored 4-beat packet then good 3-beat packet
        send_pkt(4, 1'b1, 1'b0);
        check("err_rewind_data", data_count, 0);
        send_pkt(3, 1'b0, 1'b0);
        drain(200);
        check("err_drop", drop_count, 1);
        check("err_data_after", data_count, 0);

        // Packet limit with the sink stalled
        m_ready = 1'b0;
        send_pkt(1, 1'b0, 1'b0);
        check("lim_pkt1", pkt_count, 1);
        check("lim_ready1", s_tready, 1);
        send_pkt(1, 1'b0, 1'b0);
        check("lim_pkt2", pkt_count, 2);
        check("lim_ready2", s_tready, 0);
        hold_d   = $urandom();
        hold_k   = 4'h7;
        s_tvalid = 1'b1;
        s_tdata  = hold_d;
        s_tkeep  = hold_k;
        s_tlast  = 1'b1;
        s_tuser  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("lim_hold", last_in_acc, 0);
        end
        m_ready = 1'b1;
        send_beat(hold_d, hold_k, 1'b1, 1'b0);
        drain(200);
        check("lim_data_after", data_count, 0);

        // Oversize packet: 20 beats into a 16-word buffer
        for (int i = 0; i < 16; i++) send_beat($urandom(), 4'hF, 1'b0, 1'b0);
        check("ovf_data16", data_count, 16);
        check("ovf_ready_full", s_tready, 0);
        hold_d   = $urandom();
        s_tvalid = 1'b1;
        s_tdata  = hold_d;
        s_tkeep  = 4'hF;
        s_tlast  = 1'b0;
        s_tuser  = 1'b0;
        cycle();
        check("ovf_not_acc", last_in_acc, 0);
        check("ovf_rewind_data", data_count, 0);
        check("ovf_ready_drop", s_tready, 1);
        send_beat(hold_d, 4'hF, 1'b0, 1'b0);
        send_beat($urandom(), 4'hF, 1'b0, 1'b0);
        send_beat($urandom(), 4'hF, 1'b0, 1'b0);
        send_beat($urandom(), 4'h3, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cycle();
        check("ovf_drop", drop_count, 2);
        check("ovf_valid", m_tvalid, 0);
        check("ovf_pkt", pkt_count, 0);
        check("ovf_data_end", data_count, 0);

        // Randomized traffic with sink backpressure
        rand_ready = 1'b1;
        for (int p = 0; p < 60; p++) begin
            send_pkt($urandom_range(1, 8), $urandom_range(0, 4) == 0, 1'b1);
            repeat ($urandom_range(0, 2)) cycle();
        end
        drain(3000);
        rand_ready = 1'b0;
        m_ready    = 1'b1;
        cycle();
        check("rand_data_end", data_count, 0);

        // Reset while a packet is being sent
        send_pkt(6, 1'b0, 1'b0);
        cycle();
        cycle();
        cycle();
        check("mid_valid_before", m_tvalid, 1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        #1;
        check("mid_rst_valid", m_tvalid, 0);
        check("mid_rst_pkt", pkt_count, 0);
        check("mid_rst_data", data_count, 0);
        check("mid_rst_drop", drop_count, 0);
        send_pkt(5, 1'b0, 1'b0);
        drain(200);
        check("mid_data_end", data_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
